// File: rtl/pe_pkg.sv
// Shared definitions for the PE array result drain: word width, drain FSM states
// and the settle-delay rule also reused by the feeder and the testbench.
package pe_pkg;

   localparam int RES_W = 12;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      STREAM = 2'd2
   } drain_state_t;

   // Cycles from the first fire until the farthest PE holds its final sum.
   function automatic int unsigned settle_delay(input int unsigned k,
                                                input int unsigned rows,
                                                input int unsigned cols);
      return k + rows + cols - 32'd2;
   endfunction

endpackage

// File: rtl/pe_snap_buf.sv
// Snapshot register file for the PE result drain: captures all words at once and
// offers one indexed read; a read during capture sees the incoming words.
module pe_snap_buf #(
   parameter int N     = 16,
   parameter int RES_W = 12,
   parameter int IDX_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cap,
   input  logic [N*RES_W-1:0]   in_flat,
   input  logic [IDX_W-1:0]     rd_addr,
   output logic [RES_W-1:0]     rd_data
);

   logic [RES_W-1:0] mem_r [N];

   // Storage: cleared on reset, loaded with the whole result bus on capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            mem_r[i] <= {RES_W{1'b0}};
         end
      end else if (cap) begin
         for (int i = 0; i < N; i++) begin
            mem_r[i] <= in_flat[i*RES_W +: RES_W];
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            mem_r[i] <= mem_r[i];
         end
      end
   end

   // Read mux; bypasses to the live bus on the capture edge so the first word
   // can be registered on the same edge it is captured.
   always_comb begin
      rd_data = {RES_W{1'b0}};
      if (cap) begin
         rd_data = in_flat[int'(rd_addr)*RES_W +: RES_W];
      end else begin
         rd_data = mem_r[rd_addr];
      end
   end

endmodule

// File: rtl/pe_result_drain.sv
// Result drain for the systolic PE array: waits for the array to settle, snapshots
// all results and streams them over valid/ready. PE_DRAIN_COL_MAJOR_EN selects column-major order.
module pe_result_drain
   import pe_pkg::*;
#(
   parameter int ROWS  = 4,
   parameter int COLS  = 4,
   parameter int RES_W = pe_pkg::RES_W,
   parameter int K_W   = 8
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic [K_W-1:0]                      k_len,
   output logic                                busy,
   input  logic [ROWS*COLS*RES_W-1:0]          in_res,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [RES_W-1:0]                    out_data,
   output logic [$clog2(ROWS*COLS)-1:0]        out_idx,
   output logic                                out_last
);

   localparam int N     = ROWS * COLS;
   localparam int IDX_W = $clog2(N);
   localparam int CNT_W = K_W + $clog2(ROWS + COLS) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   drain_state_t     state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [IDX_W-1:0] idx_r, idx_s;
   logic             busy_s, valid_s, last_s, cap_s;
   logic [IDX_W-1:0] oidx_s, rd_addr_s;
   logic [RES_W-1:0] data_s, rd_data_s;

   // Stream position -> buffer slot; this is also the row-major index reported.
   function automatic logic [IDX_W-1:0] stream_order(input logic [IDX_W-1:0] i);
`ifdef PE_DRAIN_COL_MAJOR_EN
      return IDX_W'((int'(i) % ROWS) * COLS + int'(i) / ROWS);
`else
      return i;
`endif
   endfunction

   pe_snap_buf #(
      .N     (N),
      .RES_W (RES_W),
      .IDX_W (IDX_W)
   ) u_snap_buf (
      .clk     (clk),
      .rst     (rst),
      .cap     (cap_s),
      .in_flat (in_res),
      .rd_addr (rd_addr_s),
      .rd_data (rd_data_s)
   );

   // Capture strobe and read address of the word to present after this edge.
   always_comb begin
      cap_s     = 1'b0;
      rd_addr_s = stream_order(idx_r + IDX_W'(1));
      if ((state_r == WAIT) && (cnt_r == CNT_W'(1))) begin
         cap_s     = 1'b1;
         rd_addr_s = stream_order(IDX_W'(0));
      end else begin
         cap_s     = 1'b0;
      end
   end

   // Next state plus next values of every registered output.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      idx_s   = idx_r;
      busy_s  = busy;
      valid_s = out_valid;
      last_s  = out_last;
      oidx_s  = out_idx;
      data_s  = out_data;
      case (state_r)
         IDLE: begin
            if (start && (k_len != {K_W{1'b0}})) begin
               state_s = WAIT;
               cnt_s   = CNT_W'(settle_delay(32'(k_len), ROWS, COLS));
               busy_s  = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         WAIT: begin
            if (cap_s) begin
               state_s = STREAM;
               cnt_s   = {CNT_W{1'b0}};
               idx_s   = {IDX_W{1'b0}};
               valid_s = 1'b1;
               last_s  = (LAST_IDX == {IDX_W{1'b0}});
               oidx_s  = rd_addr_s;
               data_s  = rd_data_s;
            end else begin
               cnt_s   = cnt_r - CNT_W'(1);
            end
         end
         STREAM: begin
            if (out_valid && out_ready && out_last) begin
               state_s = IDLE;
               idx_s   = {IDX_W{1'b0}};
               busy_s  = 1'b0;
               valid_s = 1'b0;
               last_s  = 1'b0;
               oidx_s  = {IDX_W{1'b0}};
               data_s  = {RES_W{1'b0}};
            end else if (out_valid && out_ready) begin
               idx_s   = idx_r + IDX_W'(1);
               last_s  = ((idx_r + IDX_W'(1)) == LAST_IDX);
               oidx_s  = rd_addr_s;
               data_s  = rd_data_s;
            end else begin
               state_s = STREAM;
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = {CNT_W{1'b0}};
            idx_s   = {IDX_W{1'b0}};
            busy_s  = 1'b0;
            valid_s = 1'b0;
            last_s  = 1'b0;
            oidx_s  = {IDX_W{1'b0}};
            data_s  = {RES_W{1'b0}};
         end
      endcase
   end

   // State, counter and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         cnt_r     <= {CNT_W{1'b0}};
         idx_r     <= {IDX_W{1'b0}};
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_idx   <= {IDX_W{1'b0}};
         out_data  <= {RES_W{1'b0}};
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         idx_r     <= idx_s;
         busy      <= busy_s;
         out_valid <= valid_s;
         out_last  <= last_s;
         out_idx   <= oidx_s;
         out_data  <= data_s;
      end
   end

endmodule

// File: tb/tb_pe_result_drain.sv
// Self-checking bench for pe_result_drain: directed timing scenarios plus randomized
// traffic, checked each cycle against a time-based frame model.
module tb_pe_result_drain;
   import pe_pkg::*;

   localparam int ROWS  = 4;
   localparam int COLS  = 4;
   localparam int RW    = pe_pkg::RES_W;
   localparam int K_W   = 8;
   localparam int N     = ROWS * COLS;
   localparam int IDX_W = $clog2(N);

   logic                 clk;
   logic                 rst;
   logic                 start;
   logic [K_W-1:0]       k_len;
   logic                 busy;
   logic [N*RW-1:0]      in_res;
   logic                 out_valid;
   logic                 out_ready;
   logic [RW-1:0]        out_data;
   logic [IDX_W-1:0]     out_idx;
   logic                 out_last;

   pe_result_drain #(
      .ROWS (ROWS), .COLS (COLS), .RES_W (RW), .K_W (K_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .k_len     (k_len),
      .busy      (busy),
      .in_res    (in_res),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: a frame is "active" from acceptance until its N-th handshake.
   bit          m_active = 1'b0;
   int          m_t0, m_d, m_sent;
   logic [RW-1:0] m_snap [N];
   int          cyc = 0;
   int          hs_count;
   int          first_valid;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int ord(input int i);
`ifdef PE_DRAIN_COL_MAJOR_EN
      return (i % ROWS) * COLS + i / ROWS;
`else
      return i;
`endif
   endfunction

   // One clock cycle: check outputs, drive inputs, advance the model over the edge.
   task automatic step(input bit s, input logic [K_W-1:0] k, input bit rdy, input bit r);
      bit exp_valid;
      int o;
      exp_valid = m_active && (cyc >= m_t0 + m_d + 1);
      check_eq("busy", 32'(busy), 32'(m_active));
      check_eq("out_valid", 32'(out_valid), 32'(exp_valid));
      if (exp_valid) begin
         o = ord(m_sent);
         check_eq("out_data", 32'(out_data), 32'(m_snap[o]));
         check_eq("out_idx", 32'(out_idx), 32'(o));
         check_eq("out_last", 32'(out_last), 32'(m_sent == N - 1));
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      start = s; k_len = k; out_ready = rdy; rst = r;
      if (r) begin
         m_active = 1'b0;
      end else if (!m_active) begin
         if (s && k != '0) begin
            m_active = 1'b1;
            m_t0     = cyc;
            m_d      = int'(settle_delay(32'(k), ROWS, COLS));
            m_sent   = 0;
         end
      end else begin
         if (cyc == m_t0 + m_d)
            for (int i = 0; i < N; i++) m_snap[i] = in_res[i*RW +: RW];
         if (exp_valid && rdy) begin
            m_sent++;
            hs_count++;
            if (m_sent == N) m_active = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drain_idle();
      int budget;
      budget = 0;
      while (m_active && budget < 600) begin
         step(1'b0, '0, 1'b1, 1'b0);
         budget++;
      end
      check_eq("drain_bound", 32'(m_active), 32'(0));
      step(1'b0, '0, 1'b1, 1'b0);
   endtask

   task automatic set_ramp(input int base);
      for (int i = 0; i < N; i++) in_res[i*RW +: RW] = RW'(i + base);
   endtask

   initial begin
      start = 1'b0; k_len = '0; out_ready = 1'b0; rst = 1'b1; in_res = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy", 32'(busy), 32'(0));
      check_eq("rst_valid", 32'(out_valid), 32'(0));
      check_eq("rst_last", 32'(out_last), 32'(0));
      check_eq("rst_idx", 32'(out_idx), 32'(0));
      check_eq("rst_data", 32'(out_data), 32'(0));
      step(1'b0, '0, 1'b1, 1'b1);

      // Basic frame, ready held high: valid at t+11, last at t+26.
      set_ramp(100);
      first_valid = -1; hs_count = 0; m_t0 = cyc;
      step(1'b1, 8'd4, 1'b1, 1'b0);
      check_eq("busy_rise", 32'(busy), 32'(1));
      for (int j = 0; j < 30; j++) step(1'b0, '0, 1'b1, 1'b0);
      check_eq("first_valid_lat", 32'(first_valid - m_t0), 32'(11));
      check_eq("basic_words", 32'(hs_count), 32'(16));
      drain_idle();

      // Ready toggling: 16 words, held stable while stalled.
      first_valid = -1; hs_count = 0;
      step(1'b1, 8'd4, 1'b1, 1'b0);
      for (int j = 0; j < 50; j++) step(1'b0, '0, (j % 2) == 0, 1'b0);
      check_eq("toggle_words", 32'(hs_count), 32'(16));
      drain_idle();

      // Starts during WAIT and STREAM are ignored.
      hs_count = 0;
      step(1'b1, 8'd4, 1'b1, 1'b0);
      for (int j = 1; j < 40; j++) step(j == 5 || j == 15, 8'd4, 1'b1, 1'b0);
      check_eq("busy_starts_words", 32'(hs_count), 32'(16));
      drain_idle();

      // k_len == 0 start is ignored.
      first_valid = -1;
      step(1'b1, 8'd0, 1'b1, 1'b0);
      for (int j = 0; j < 20; j++) step(1'b0, '0, 1'b1, 1'b0);
      check_eq("k0_no_valid", 32'(first_valid < 0), 32'(1));

      // Reset mid-stream, then a k_len=1 frame: first valid 8 cycles later.
      set_ramp(200);
      step(1'b1, 8'd4, 1'b1, 1'b0);
      for (int j = 1; j < 13; j++) step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b1);
      check_eq("midrst_data", 32'(out_data), 32'(0));
      check_eq("midrst_idx", 32'(out_idx), 32'(0));
      first_valid = -1; m_t0 = cyc;
      step(1'b1, 8'd1, 1'b1, 1'b0);
      for (int j = 0; j < 25; j++) step(1'b0, '0, 1'b1, 1'b0);
      check_eq("k1_latency", 32'(first_valid - m_t0), 32'(8));
      drain_idle();

      // Randomized traffic.
      for (int j = 0; j < 4000; j++) begin
         logic [K_W-1:0] k;
         for (int i = 0; i < N; i++) in_res[i*RW +: RW] = RW'($urandom);
         if ($urandom_range(0, 3) == 0) k = '0;
         else if ($urandom_range(0, 40) == 0) k = 8'hFF;
         else k = K_W'($urandom_range(1, 20));
         step(($urandom % 6) == 0, k, ($urandom % 3) != 0, ($urandom % 400) == 0);
      end
      drain_idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
